// File: rtl/piso_sr_tx_if.sv
// Handshake and serial-link signals of the PISO transmitter, bundled for port use.
// master = word producer / link observer side, slave = transmitter side.
interface piso_sr_tx_if #(
  parameter int WIDTH = 16
);
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic             done;
  logic             SC;
  logic             CS;
  logic             SIO;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, done, SC, CS, SIO
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, done, SC, CS, SIO
  );
endinterface

// File: rtl/piso_sr_tx.sv
// Serial link master transmitter: takes one word per valid/ready accept and emits it
// MSB-first on SIO under CS, with SC generated by dividing CLK by 2*CLK_DIV.
module piso_sr_tx #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic         CLK,
  input  logic         RESET_N,
  piso_sr_tx_if.slave  bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_div_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-2:0] r_shift;
  logic             r_sc;
  logic             r_cs;
  logic             r_sio;
  logic             r_done;

  logic             w_div_end;

  assign w_div_end    = (r_div_cnt == DIV_LAST);
  assign bus.tx_ready = (r_state == S_IDLE);
  assign bus.done     = r_done;
  assign bus.SC       = r_sc;
  assign bus.CS       = r_cs;
  assign bus.SIO      = r_sio;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_sc      <= 1'b0;
      r_cs      <= 1'b1;
      r_sio     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_div_cnt <= w_div_end ? '0 : r_div_cnt + DW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (bus.tx_valid) begin
            // MSB goes straight to SIO; the shifter only holds the remaining bits
            r_shift   <= bus.tx_data[WIDTH-2:0];
            r_sio     <= bus.tx_data[WIDTH-1];
            r_cs      <= 1'b0;
            r_bit_cnt <= BW'(WIDTH - 1);
            r_div_cnt <= '0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_sc    <= 1'b1;
            r_state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_div_end) begin
            r_sc    <= 1'b0;
            r_state <= (r_bit_cnt == '0) ? S_HOLD : S_LOW;
          end
        end
        S_LOW: begin
          if (w_div_end) begin
            r_sc      <= 1'b1;
            r_sio     <= r_shift[WIDTH-2];
            r_shift   <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt - BW'(1);
            r_state   <= S_HIGH;
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_cs    <= 1'b1;
            r_sio   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_sr_tx.sv
// Bench for piso_sr_tx: two instances (CLK_DIV=4 and CLK_DIV=1) observed by a
// behavioural falling-edge receiver and link-rule monitor.
module tb_piso_sr_tx;

  localparam int W  = 16;
  localparam int DA = 4;
  localparam int DB = 1;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  piso_sr_tx_if #(.WIDTH(W)) ifa ();
  piso_sr_tx_if #(.WIDTH(W)) ifb ();

  piso_sr_tx #(.WIDTH(W), .CLK_DIV(DA)) dut_a (.CLK(CLK), .RESET_N(RESET_N), .bus(ifa.slave));
  piso_sr_tx #(.WIDTH(W), .CLK_DIV(DB)) dut_b (.CLK(CLK), .RESET_N(RESET_N), .bus(ifb.slave));

  typedef struct {
    logic [W-1:0] rx;
    int len;
    int falls;
    int start;
    int stop;
    int rise_tog;
  } frame_t;

  typedef struct {
    int           sel;
    logic [W-1:0] din;
    logic [W-1:0] exp_word;
    int           exp_len;
    int           exp_falls;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  frame_t qa[$];
  frame_t qb[$];

  logic         p_cs [2];
  logic         p_sc [2];
  logic         p_sio[2];
  logic [W-1:0] rx_sr[2];
  int low_cnt[2], fall_cnt[2], tog[2], start_c[2];
  int sc_viol[2], sio_viol[2], done_viol[2], rdy_viol[2], done_cnt[2], frames[2];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference receiver: shifts SIO on every falling SC while CS is low, and
  // tallies any breach of the link rules (SC/SIO/done/ready relationships).
  task automatic mon(input int m, input logic cs, input logic sc, input logic sio,
                     input logic dn, input logic rdy);
    frame_t f;
    if (!RESET_N) begin
      p_cs[m] = 1'b1; p_sc[m] = 1'b0; p_sio[m] = 1'b0;
      low_cnt[m] = 0; fall_cnt[m] = 0; tog[m] = 0; rx_sr[m] = '0;
      return;
    end
    if (p_cs[m] && !cs) begin
      start_c[m] = cyc; low_cnt[m] = 0; fall_cnt[m] = 0; tog[m] = 0; rx_sr[m] = '0;
    end
    if (cs && sc) sc_viol[m]++;
    if (cs && p_cs[m] && sc !== p_sc[m]) sc_viol[m]++;
    if (sio !== p_sio[m]) begin
      if (!((p_cs[m] && !cs) || (!p_sc[m] && sc) || (!p_cs[m] && cs))) sio_viol[m]++;
      if (!p_sc[m] && sc) tog[m]++;
    end
    if (cs && p_cs[m] && sio !== 1'b0) sio_viol[m]++;
    if (dn !== (!p_cs[m] && cs)) done_viol[m]++;
    if (dn === 1'b1) done_cnt[m]++;
    if (rdy !== cs) rdy_viol[m]++;
    if (!cs) begin
      low_cnt[m]++;
      if (p_sc[m] && !sc) begin
        rx_sr[m] = {rx_sr[m][W-2:0], sio};
        fall_cnt[m]++;
      end
    end
    if (!p_cs[m] && cs) begin
      f.rx = rx_sr[m]; f.len = low_cnt[m]; f.falls = fall_cnt[m];
      f.start = start_c[m]; f.stop = cyc; f.rise_tog = tog[m];
      frames[m]++;
      if (m == 0) qa.push_back(f); else qb.push_back(f);
    end
    p_cs[m] = cs; p_sc[m] = sc; p_sio[m] = sio;
  endtask

  always @(negedge CLK) mon(0, ifa.CS, ifa.SC, ifa.SIO, ifa.done, ifa.tx_ready);
  always @(negedge CLK) mon(1, ifb.CS, ifb.SC, ifb.SIO, ifb.done, ifb.tx_ready);

  // Present a word and wait (bounded) for the accepting edge; returns just after it.
  task automatic send(input int m, input logic [W-1:0] w, input bit keep, output bit ok);
    logic r;
    ok = 1'b0;
    if (m == 0) begin ifa.tx_valid = 1'b1; ifa.tx_data = w; end
    else        begin ifb.tx_valid = 1'b1; ifb.tx_data = w; end
    for (int i = 0; i < 2000 && !ok; i++) begin
      r = (m == 0) ? ifa.tx_ready : ifb.tx_ready;
      @(posedge CLK);
      #1;
      if (r) ok = 1'b1;
    end
    if (!keep) begin
      if (m == 0) ifa.tx_valid = 1'b0; else ifb.tx_valid = 1'b0;
    end
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic get_frame(input int m, input string tag, output frame_t f, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ((m == 0 && qa.size() > 0) || (m == 1 && qb.size() > 0)) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
    end
    chk({tag, "_seen"}, {31'd0, ok}, 32'd1);
    if (ok) f = (m == 0) ? qa.pop_front() : qb.pop_front();
  endtask

  task automatic check_frame(input int m, input logic [W-1:0] exp_w, input string tag,
                             output frame_t f);
    bit ok;
    int d;
    d = (m == 0) ? DA : DB;
    get_frame(m, tag, f, ok);
    if (ok) begin
      chk({tag, "_rx"},    {16'd0, f.rx}, {16'd0, exp_w});
      chk({tag, "_len"},   f.len,   (2 * W + 1) * d);
      chk({tag, "_falls"}, f.falls, W);
    end
  endtask

  vec_t   vecs[7];
  frame_t f, f1, f2;
  bit     ok;
  int     sc_hi, ready_hi;
  logic [W-1:0] model_q[$];

  initial begin
    for (int m = 0; m < 2; m++) begin
      sc_viol[m] = 0; sio_viol[m] = 0; done_viol[m] = 0; rdy_viol[m] = 0;
      done_cnt[m] = 0; frames[m] = 0;
    end
    ifa.tx_valid = 1'b0; ifa.tx_data = '0;
    ifb.tx_valid = 1'b0; ifb.tx_data = '0;

    vecs[0] = '{0, 16'hA5C3, 16'hA5C3, (2*W+1)*DA, W};
    vecs[1] = '{0, 16'h0000, 16'h0000, (2*W+1)*DA, W};
    vecs[2] = '{0, 16'h8000, 16'h8000, (2*W+1)*DA, W};
    vecs[3] = '{0, 16'h0001, 16'h0001, (2*W+1)*DA, W};
    vecs[4] = '{1, 16'h5555, 16'h5555, (2*W+1)*DB, W};
    vecs[5] = '{1, 16'hFFFF, 16'hFFFF, (2*W+1)*DB, W};
    vecs[6] = '{1, 16'h3C96, 16'h3C96, (2*W+1)*DB, W};

    // Reset held: outputs at idle values, no SC activity.
    sc_hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ifa.SC !== 1'b0 || ifb.SC !== 1'b0) sc_hi++;
    end
    chk("rst_cs",    {31'd0, ifa.CS},       32'd1);
    chk("rst_sc",    {31'd0, ifa.SC},       32'd0);
    chk("rst_sio",   {31'd0, ifa.SIO},      32'd0);
    chk("rst_done",  {31'd0, ifa.done},     32'd0);
    chk("rst_ready", {31'd0, ifa.tx_ready}, 32'd1);
    chk("rst_sc_quiet", sc_hi, 0);
    RESET_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    foreach (vecs[i]) begin
      send(vecs[i].sel, vecs[i].din, 1'b0, ok);
      get_frame(vecs[i].sel, "vec", f, ok);
      if (ok) begin
        chk("vec_rx",    {16'd0, f.rx}, {16'd0, vecs[i].exp_word});
        chk("vec_len",   f.len,   vecs[i].exp_len);
        chk("vec_falls", f.falls, vecs[i].exp_falls);
        if (vecs[i].din == 16'h5555) chk("div1_sio_tog", f.rise_tog, W - 1);
      end
      repeat (2) @(posedge CLK);
      #1;
    end

    // Back-to-back with tx_valid held across the boundary.
    send(0, 16'hFFFF, 1'b1, ok);
    ifa.tx_data = 16'h0001;
    send(0, 16'h0001, 1'b0, ok);
    check_frame(0, 16'hFFFF, "b2b1", f1);
    check_frame(0, 16'h0001, "b2b2", f2);
    chk("b2b_gap", f2.start - f1.stop, 1);

    // Busy-time valid/data activity must not disturb the frame.
    send(0, 16'h00FF, 1'b0, ok);
    repeat (40) @(posedge CLK);
    #1;
    ready_hi = 0;
    for (int i = 0; i < 20; i++) begin
      ifa.tx_valid = 1'b1;
      ifa.tx_data  = (i % 2 == 0) ? 16'h1234 : 16'hEDCB;
      if (ifa.tx_ready) ready_hi++;
      @(posedge CLK);
      #1;
    end
    ifa.tx_valid = 1'b0;
    chk("busy_ready", ready_hi, 0);
    check_frame(0, 16'h00FF, "busy", f);
    repeat (150) @(posedge CLK);
    chk("busy_no_extra", qa.size(), 0);

    // Asynchronous abort after the 7th SC fall.
    #1;
    send(0, 16'hC3A5, 1'b0, ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge CLK);
      if (fall_cnt[0] == 7) ok = 1'b1;
    end
    chk("abort_reach7", {31'd0, ok}, 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("abort_cs", {31'd0, ifa.CS}, 32'd1);
    chk("abort_sc", {31'd0, ifa.SC}, 32'd0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_no_frame", qa.size(), 0);
    send(0, 16'h8001, 1'b0, ok);
    check_frame(0, 16'h8001, "post_abort", f);

    // Random words against the queue model, both instances, random idle gaps.
    for (int i = 0; i < 24; i++) begin
      int m;
      logic [W-1:0] w, e;
      m = $urandom_range(0, 1);
      w = W'($urandom);
      send(m, w, 1'b0, ok);
      model_q.push_back(w);
      e = model_q.pop_front();
      check_frame(m, e, "rand", f);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end

    repeat (5) @(posedge CLK);
    for (int m = 0; m < 2; m++) begin
      chk("sc_rules",   sc_viol[m],   0);
      chk("sio_rules",  sio_viol[m],  0);
      chk("done_rules", done_viol[m], 0);
      chk("ready_rules", rdy_viol[m], 0);
      chk("done_count", done_cnt[m],  frames[m]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
